// File: rtl/numacc_pkg.sv
// Shared types and helpers for the number accumulator: token width, FSM
// state encoding and the signed-limit magnitude function.
package numacc_pkg;

  localparam int TOKEN_W = 4;
  // Wide enough for a 64-bit result extended by the 5 MAC guard bits.
  localparam int LIMIT_W = 70;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Largest magnitude representable for the given sign:
  // 2^(width-1) when negative, 2^(width-1)-1 when positive.
  function automatic logic [LIMIT_W-1:0] limit_mag(input int width, input logic neg);
    logic [LIMIT_W-1:0] lim;
    lim = {{(LIMIT_W-1){1'b0}}, 1'b1} << (width - 1);
    if (!neg) lim = lim - {{(LIMIT_W-1){1'b0}}, 1'b1};
    return lim;
  endfunction

endpackage

// File: rtl/digit_mac.sv
// Combinational digit step: mag*RADIX + digit, checked against the limit of
// the requested sign, with freeze or clamp on overflow.
module digit_mac
  import numacc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int RADIX    = 10,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0]   mag_in,
  input  logic [TOKEN_W-1:0] digit,
  input  logic               neg,
  input  logic               force_over,
  output logic [WIDTH-1:0]   mag_out,
  output logic               over
);

  localparam int EXT_W = WIDTH + 5;

  logic [LIMIT_W-1:0] lim;
  logic [EXT_W-1:0]   ext;

  always_comb begin
    lim     = limit_mag(WIDTH, neg);
    ext     = EXT_W'(mag_in) * EXT_W'(RADIX) + EXT_W'(digit);
    over    = force_over || (LIMIT_W'(ext) > lim);
    mag_out = ext[WIDTH-1:0];
    // Freeze keeps the last good magnitude; saturate pins it at the limit.
    if (over) mag_out = (SATURATE != 0) ? lim[WIDTH-1:0] : mag_in;
  end

endmodule

// File: rtl/number_accumulator.sv
// Digit-stream accumulator: builds a signed operand from radix digit tokens
// and holds it on a valid/ready output until the stack datapath takes it.
module number_accumulator
  import numacc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX      = 10,
  parameter int MAX_DIGITS = 10,
  parameter int SATURATE   = 0,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [TOKEN_W-1:0]      token,
  input  logic                    token_valid,
  output logic                    token_ready,
  input  logic                    negate,
  input  logic                    commit,
  output logic signed [WIDTH-1:0] number,
  output logic                    number_valid,
  input  logic                    number_ready,
  output logic                    digit_ack,
  output logic                    bad_token,
  output logic                    overflow,
  output logic [CNT_W-1:0]        digit_count,
  output logic [1:0]              state_dbg
);

  // Handshakes: a token transfers on a rising edge where token_valid and
  // token_ready are both high; the result transfers on a rising edge where
  // number_valid and number_ready are both high. number/overflow stay
  // stable for as long as number_valid is high.

  state_t             state;
  logic [WIDTH-1:0]   mag;
  logic               sign;

  logic               in_range;
  logic               digit_fire;
  logic               bad_fire;
  logic               neg_fire;
  logic               new_sign;
  logic               at_max;
  logic               force_over;
  logic               commit_fire;
  logic               mac_over;
  logic               over_next;
  logic               fin_over;
  logic [WIDTH-1:0]   mac_mag;
  logic [WIDTH-1:0]   mag_next;
  logic [WIDTH-1:0]   fin_mag;
  logic [LIMIT_W-1:0] fin_lim;

  assign token_ready  = (state != HOLD);
  assign number_valid = (state == HOLD);
  assign state_dbg    = state;

  assign in_range    = ({1'b0, token} < (TOKEN_W + 1)'(RADIX));
  assign digit_fire  = token_valid && token_ready && in_range;
  assign bad_fire    = token_valid && token_ready && !in_range;
  assign neg_fire    = negate && (state != HOLD);
  assign new_sign    = sign ^ neg_fire;
  assign at_max      = (digit_count == CNT_W'(MAX_DIGITS));
  // After a frozen overflow every later digit is acknowledged but discarded.
  assign force_over  = at_max || (overflow && (SATURATE == 0));
  // A commit that arrives with the first digit or negate still counts.
  assign commit_fire = commit && ((state == BUILD) || digit_fire || neg_fire);

  digit_mac #(
    .WIDTH    (WIDTH),
    .RADIX    (RADIX),
    .SATURATE (SATURATE)
  ) u_mac (
    .mag_in     (mag),
    .digit      (token),
    .neg        (new_sign),
    .force_over (force_over),
    .mag_out    (mac_mag),
    .over       (mac_over)
  );

  // A negate after the digits can push the magnitude past the positive
  // limit, so the final value is re-checked against the final sign.
  always_comb begin
    mag_next  = digit_fire ? mac_mag : mag;
    over_next = overflow | (digit_fire & mac_over);
    fin_lim   = limit_mag(WIDTH, new_sign);
    fin_over  = LIMIT_W'(mag_next) > fin_lim;
    fin_mag   = (fin_over && (SATURATE != 0)) ? fin_lim[WIDTH-1:0] : mag_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mag         <= '0;
      sign        <= 1'b0;
      number      <= '0;
      digit_ack   <= 1'b0;
      bad_token   <= 1'b0;
      overflow    <= 1'b0;
      digit_count <= '0;
    end else begin
      digit_ack <= 1'b0;
      bad_token <= 1'b0;
      if (clear) begin
        state       <= IDLE;
        mag         <= '0;
        sign        <= 1'b0;
        number      <= '0;
        overflow    <= 1'b0;
        digit_count <= '0;
      end else begin
        case (state)
          IDLE, BUILD: begin
            digit_ack <= digit_fire;
            bad_token <= bad_fire;
            mag       <= mag_next;
            sign      <= new_sign;
            overflow  <= over_next;
            if (digit_fire && !at_max) digit_count <= digit_count + CNT_W'(1);
            if (commit_fire) begin
              number   <= new_sign ? -fin_mag : fin_mag;
              mag      <= fin_mag;
              overflow <= over_next | fin_over;
              state    <= HOLD;
            end else if (digit_fire || neg_fire) begin
              state <= BUILD;
            end
          end
          HOLD: begin
            if (number_ready) begin
              state       <= IDLE;
              mag         <= '0;
              sign        <= 1'b0;
              overflow    <= 1'b0;
              digit_count <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_number_accumulator.sv
// Bench for number_accumulator: a decimal freeze instance and a hex
// saturating instance share one stimulus set, selected by sel.
module tb_number_accumulator;

  localparam int W = 32;
  localparam logic [3:0] INT_MIN_D [10] = '{4'd2, 4'd1, 4'd4, 4'd7, 4'd4,
                                            4'd8, 4'd3, 4'd6, 4'd4, 4'd8};

  logic       clk = 1'b0;
  logic       rst, sel, clear, negate, commit, token_valid, number_ready;
  logic [3:0] token;

  logic tv0, tv1, ng0, ng1, cm0, cm1, cl0, cl1;
  assign tv0 = token_valid & ~sel;
  assign tv1 = token_valid &  sel;
  assign ng0 = negate & ~sel;
  assign ng1 = negate &  sel;
  assign cm0 = commit & ~sel;
  assign cm1 = commit &  sel;
  assign cl0 = clear & ~sel;
  assign cl1 = clear &  sel;

  logic [W-1:0] number0, number1;
  logic         nv0, nv1, tr0, tr1, da0, da1, bt0, bt1, ov0, ov1;
  logic [3:0]   dc0, dc1;
  logic [1:0]   st0, st1;

  logic [W-1:0] obs_number;
  logic         obs_valid, obs_ready, obs_ack, obs_bad, obs_ov;
  logic [3:0]   obs_dc;
  assign obs_number = sel ? number1 : number0;
  assign obs_valid  = sel ? nv1 : nv0;
  assign obs_ready  = sel ? tr1 : tr0;
  assign obs_ack    = sel ? da1 : da0;
  assign obs_bad    = sel ? bt1 : bt0;
  assign obs_ov     = sel ? ov1 : ov0;
  assign obs_dc     = sel ? dc1 : dc0;

  number_accumulator #(.WIDTH(W), .RADIX(10), .MAX_DIGITS(10), .SATURATE(0)) u_dec (
    .clk(clk), .rst(rst), .clear(cl0), .token(token), .token_valid(tv0),
    .token_ready(tr0), .negate(ng0), .commit(cm0), .number(number0),
    .number_valid(nv0), .number_ready(number_ready), .digit_ack(da0),
    .bad_token(bt0), .overflow(ov0), .digit_count(dc0), .state_dbg(st0)
  );

  number_accumulator #(.WIDTH(W), .RADIX(16), .MAX_DIGITS(8), .SATURATE(1)) u_hex (
    .clk(clk), .rst(rst), .clear(cl1), .token(token), .token_valid(tv1),
    .token_ready(tr1), .negate(ng1), .commit(cm1), .number(number1),
    .number_valid(nv1), .number_ready(number_ready), .digit_ack(da1),
    .bad_token(bt1), .overflow(ov1), .digit_count(dc1), .state_dbg(st1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  // Scoreboard: {overflow, number} compared just before each accepting edge.
  always @(negedge clk) begin
    if (!rst && obs_valid && number_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %0d with empty queue", obs_number);
      end else begin
        logic [W:0] exp;
        exp = exp_q.pop_front();
        if ({obs_ov, obs_number} !== exp)
          begin
            n_fail++;
            $display("FAIL result: got ovf=%b num=%h expected ovf=%b num=%h",
                     obs_ov, obs_number, exp[W], exp[W-1:0]);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] t);
    token       = t;
    token_valid = 1'b1;
    tick();
    token_valid = 1'b0;
  endtask

  task automatic pulse_negate();
    negate = 1'b1;
    tick();
    negate = 1'b0;
  endtask

  task automatic do_commit(input logic [W:0] exp);
    exp_q.push_back(exp);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic accept();
    number_ready = 1'b1;
    tick();
    number_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({nv0, tr0, da0, bt0, ov0} !== 5'b01000 || {nv1, tr1, da1, bt1, ov1} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b/%b expected 01000", {nv0, tr0, da0, bt0, ov0},
               {nv1, tr1, da1, bt1, ov1});
    end
    n_checks++;
    if (number0 !== '0 || dc0 !== 4'd0 || dc1 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_values: number=%h dc0=%0d dc1=%0d expected 0", number0, dc0, dc1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int acks;
    sel  = 1'b0;
    acks = 0;
    for (int i = 1; i <= 3; i++) begin
      send_digit(4'(i));
      if (obs_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 3 || obs_dc !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_acks: got acks=%0d count=%0d expected 3/3", acks, obs_dc);
    end
    do_commit({1'b0, 32'd123});
    n_checks++;
    if (obs_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: got %b expected 1", obs_valid);
    end
    accept();
    n_checks++;
    if (obs_ready !== 1'b1 || obs_dc !== 4'd0 || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: got ready=%b count=%0d valid=%b expected 1/0/0",
               obs_ready, obs_dc, obs_valid);
    end
  endtask

  task automatic test_int_min();
    sel = 1'b0;
    pulse_negate();
    for (int i = 0; i < 10; i++) send_digit(INT_MIN_D[i]);
    n_checks++;
    if (obs_dc !== 4'd10) begin
      n_fail++;
      $display("FAIL int_min_count: got %0d expected 10", obs_dc);
    end
    do_commit({1'b0, 32'h8000_0000});
    accept();
    for (int i = 0; i < 10; i++) send_digit(INT_MIN_D[i]);
    do_commit({1'b1, 32'd214748364});
    accept();
    // Sign flipped back to + after the digits: overflow found at commit.
    pulse_negate();
    for (int i = 0; i < 10; i++) send_digit(INT_MIN_D[i]);
    pulse_negate();
    do_commit({1'b1, 32'h8000_0000});
    accept();
  endtask

  task automatic test_saturate();
    sel = 1'b1;
    send_digit(4'hF);
    send_digit(4'hF);
    send_digit(4'hA);
    n_checks++;
    if (obs_dc !== 4'd3) begin
      n_fail++;
      $display("FAIL hex_count: got %0d expected 3", obs_dc);
    end
    send_digit(4'h3);
    do_commit({1'b0, 32'd65443});
    accept();
    send_digit(4'h8);
    for (int i = 0; i < 7; i++) send_digit(4'h0);
    do_commit({1'b1, 32'h7FFF_FFFF});
    accept();
    pulse_negate();
    send_digit(4'h8);
    for (int i = 0; i < 7; i++) send_digit(4'h0);
    do_commit({1'b0, 32'h8000_0000});
    accept();
    for (int i = 0; i < 9; i++) send_digit(4'h1);
    n_checks++;
    if (obs_dc !== 4'd8 || obs_ov !== 1'b1) begin
      n_fail++;
      $display("FAIL max_digits: got count=%0d ovf=%b expected 8/1", obs_dc, obs_ov);
    end
    do_commit({1'b1, 32'h7FFF_FFFF});
    accept();
  endtask

  task automatic test_bad_token();
    sel = 1'b0;
    send_digit(4'd5);
    send_digit(4'd12);
    n_checks++;
    if (obs_bad !== 1'b1 || obs_ack !== 1'b0 || obs_dc !== 4'd1) begin
      n_fail++;
      $display("FAIL bad_token: got bad=%b ack=%b count=%0d expected 1/0/1",
               obs_bad, obs_ack, obs_dc);
    end
    tick();
    n_checks++;
    if (obs_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_token_pulse: got %b expected 0", obs_bad);
    end
    do_commit({1'b0, 32'd5});
    accept();
  endtask

  task automatic test_hold();
    sel = 1'b0;
    send_digit(4'd9);
    do_commit({1'b0, 32'd9});
    token       = 4'd3;
    token_valid = 1'b1;
    negate      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_number !== 32'd9) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got ready=%b valid=%b num=%0d expected 0/1/9",
                 i, obs_ready, obs_valid, obs_number);
      end
      tick();
    end
    token_valid = 1'b0;
    negate      = 1'b0;
    accept();
    n_checks++;
    if (obs_ready !== 1'b1 || obs_dc !== 4'd0 || obs_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got ready=%b count=%0d ovf=%b expected 1/0/0",
               obs_ready, obs_dc, obs_ov);
    end
    send_digit(4'd6);
    do_commit({1'b0, 32'd6});
    accept();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    send_digit(4'd4);
    send_digit(4'd2);
    exp_q.push_back({1'b0, 32'd425});
    token       = 4'd5;
    token_valid = 1'b1;
    commit      = 1'b1;
    tick();
    token_valid = 1'b0;
    commit      = 1'b0;
    accept();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_commit: got valid=%b expected 0", obs_valid);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    sel = 1'b0;
    send_digit(4'd3);
    send_digit(4'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (obs_valid !== 1'b0 || obs_dc !== 4'd0 || obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_build: got valid=%b count=%0d ready=%b expected 0/0/1",
               obs_valid, obs_dc, obs_ready);
    end
    send_digit(4'd5);
    do_commit({1'b0, 32'd5});
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    n_checks++;
    if (obs_valid !== 1'b0 || obs_dc !== 4'd0 || obs_number !== '0) begin
      n_fail++;
      $display("FAIL rst_hold: got valid=%b count=%0d num=%0d expected 0/0/0",
               obs_valid, obs_dc, obs_number);
    end
    tick();
    rst = 1'b0;
    tick();
    send_digit(4'd7);
    do_commit({1'b0, 32'd7});
    accept();
  endtask

  initial begin
    rst          = 1'b1;
    sel          = 1'b0;
    clear        = 1'b0;
    negate       = 1'b0;
    commit       = 1'b0;
    token        = 4'd0;
    token_valid  = 1'b0;
    number_ready = 1'b0;
    test_reset();
    test_basic();
    test_int_min();
    test_saturate();
    test_bad_token();
    test_hold();
    test_back_to_back();
    test_abort();
    repeat (2) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_results: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/number_accumulator.md
# number_accumulator

Parametrised digit-stream accumulator for the stack calculator front end. Consumes digit tokens from the tokenizer over a valid/ready handshake, builds a signed two's-complement value in a configurable radix and width, detects overflow, optionally saturates, and presents the finished operand on a valid/ready output held until the stack datapath accepts it. Sits between the token decoder and the operand push logic.

## Interface
- WIDTH, 32, result width in bits (8..64)
- RADIX, 10, digit base (2..16)
- MAX_DIGITS, 10, maximum accepted digits per number (1..20)
- SATURATE, 0, 0 = overflow freezes value; 1 = overflow clamps to limit
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort, discards partial number and held result
- token  in  4  digit value
- token_valid  in  1  token present
- token_ready  out  1  block can accept a digit
- negate  in  1  single-cycle strobe, toggles sign of number under construction
- commit  in  1  single-cycle strobe, finishes current number
- number  out  WIDTH  signed result, valid while number_valid
- number_valid  out  1  result held
- number_ready  in  1  consumer accepts result
- digit_ack  out  1  one-cycle pulse after each accepted in-range digit
- bad_token  out  1  one-cycle pulse after accepted token >= RADIX
- overflow  out  1  sticky per number; valid alongside number
- digit_count  out  $clog2(MAX_DIGITS+1)  digits accumulated so far

## Operation
- States: IDLE (no digits, sign +), BUILD (≥1 digit or negate seen), HOLD (result presented).
- token_ready = 1 in IDLE/BUILD, 0 in HOLD.
- Accepted token < RADIX: mag <= mag*RADIX + token, digit_count++, digit_ack next cycle; IDLE->BUILD.
- Accepted token >= RADIX: no state change except bad_token pulse.
- negate in IDLE/BUILD: toggle sign; IDLE->BUILD. Ignored in HOLD.
- Limits: positive 2^(WIDTH-1)-1, negative magnitude 2^(WIDTH-1). MAC computed in WIDTH+5 bits, compared against limit of current sign at final sign (negate after digits re-checks: +2^(W-1) magnitude with sign + is overflow at commit).
- Overflow, SATURATE=0: set overflow, magnitude unchanged, further digits acknowledged but discarded. SATURATE=1: magnitude clamps to limit, overflow set.
- Digit beyond MAX_DIGITS: treated as overflow (same rules), digit_count stays at MAX_DIGITS.
- commit in BUILD: number <= sign ? -mag : mag; -> HOLD. commit in IDLE: ignored, no output. commit in HOLD: ignored.
- HOLD: number_valid=1; on number_ready -> IDLE, magnitude, sign, overflow, digit_count cleared.
- Priority: rst > clear > handshake logic. clear in any state -> IDLE next cycle, number_valid drops.

## Timing
- Reset values: number=0, number_valid=0, token_ready=1 (IDLE), digit_ack=0, bad_token=0, overflow=0, digit_count=0.
- Digit accepted at edge N -> magnitude/digit_count updated and digit_ack high in cycle N+1 only.
- commit at edge N -> number_valid high from cycle N+1; number stable until handshake.
- Same-cycle digit + commit: digit absorbed first, result includes it; overflow from that digit reflected.
- Same-cycle digit + negate: both applied; overflow checked against new sign.
- number_valid & number_ready at edge N -> token_ready high in cycle N+1; no back-to-back acceptance in HOLD.
- rst asserted mid-BUILD or mid-HOLD: all outputs to reset values immediately, asynchronously.

## Structure
- Package numacc_pkg: TOKEN_W=4, state enum (IDLE, BUILD, HOLD), function returning signed limit magnitude for WIDTH and sign.
- Sub-module digit_mac: combinational mag*RADIX+digit with overflow/clamp, parametrised by WIDTH, RADIX, SATURATE; top keeps FSM, counters, output register.

## Test plan
- Default params, digits 1,2,3 then commit -> number=123, overflow=0, three digit_ack pulses, digit_count=3.
- negate, digits 2,1,4,7,4,8,3,6,4,8, commit -> number=-2147483648, overflow=0; same without negate -> overflow=1, number=214748364 (SATURATE=0) or 2147483647 (SATURATE=1).
- RADIX=16, tokens F,F,A, token 3 -> 4090 path; then RADIX=10 token 12 -> bad_token pulse, value unchanged.
- Hold with number_ready=0 for 5 cycles while token_valid=1 -> token_ready=0, number unchanged; ready=1 -> IDLE next cycle, counters cleared.
- Digit with commit same cycle after 4,2 -> number=425; commit in IDLE -> no number_valid.
- clear mid-BUILD and rst mid-HOLD -> number_valid=0, digit_count=0, next number 7 commits as 7.
